// File: rtl/sample_feeder_if.sv
// Sample feeder bus: feed control, sample-memory read port and the
// subchannel sample strobe outputs, bundled for one feeder instance.
interface sample_feeder_if #(
    parameter int INPUT_WIDTH = 3,
    parameter int ADDR_WIDTH  = 14
);
    logic                   start;
    logic [ADDR_WIDTH-1:0]  start_addr;
    logic [ADDR_WIDTH-1:0]  num_samples;
    logic                   abort;
    logic                   stall;
    logic                   busy;
    logic                   done;
    logic                   mem_rd_en;
    logic [ADDR_WIDTH-1:0]  mem_rd_addr;
    logic [INPUT_WIDTH-1:0] mem_rd_data;
    logic                   data_available;
    logic [INPUT_WIDTH-1:0] data;
    logic                   feed_complete;

    modport master (
        input  start, start_addr, num_samples, abort, stall, mem_rd_data,
        output busy, done, mem_rd_en, mem_rd_addr, data_available, data,
               feed_complete
    );

    modport slave (
        output start, start_addr, num_samples, abort, stall, mem_rd_data,
        input  busy, done, mem_rd_en, mem_rd_addr, data_available, data,
               feed_complete
    );
endinterface

// File: rtl/sample_feeder.sv
// Streams a programmed span of the circular sample memory onto the shared
// subchannel sample bus, flagging the final sample with feed_complete.
//
// state  | meaning
// IDLE   | waiting for a start with a nonzero span
// ISSUE  | issuing memory reads, paced by stall and the gap down-counter
// DRAIN  | all reads issued, waiting for the final sample to leave the pipe
// FINISH | one-cycle done pulse, then back to IDLE
module sample_feeder #(
    parameter int INPUT_WIDTH = 3,
    parameter int ADDR_WIDTH  = 14,
    parameter int RD_LATENCY  = 2,
    parameter int FEED_GAP    = 0
) (
    input  logic            clk,
    input  logic            global_reset,
    sample_feeder_if.master bus
);
    localparam int GAP_W = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [ADDR_WIDTH-1:0]  cnt_q, cnt_d;
    logic [GAP_W-1:0]       gap_q, gap_d;
    logic [RD_LATENCY-1:0]  vld_q, vld_d;
    logic [RD_LATENCY-1:0]  last_q, last_d;
    logic [INPUT_WIDTH-1:0] data_q, data_d;

    logic issue;
    logic squash;
    logic out_valid;
    logic out_last;

    always_ff @(posedge clk) begin
        if (global_reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            gap_q   <= '0;
            vld_q   <= '0;
            last_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            vld_q   <= vld_d;
            last_q  <= last_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        gap_d     = (gap_q != '0) ? gap_q - GAP_W'(1) : gap_q;
        data_d    = data_q;
        issue     = 1'b0;
        squash    = 1'b0;
        out_valid = vld_q[RD_LATENCY-1];
        out_last  = last_q[RD_LATENCY-1];

        if (out_valid) begin
            data_d = bus.mem_rd_data;
        end

        case (state_q)
            IDLE: begin
                if (bus.start && (bus.num_samples != '0)) begin
                    addr_d  = bus.start_addr;
                    cnt_d   = bus.num_samples;
                    gap_d   = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.abort) begin
                    squash  = 1'b1;
                    state_d = IDLE;
                end else if (!bus.stall && (gap_q == '0)) begin
                    issue  = 1'b1;
                    addr_d = addr_q + ADDR_WIDTH'(1);
                    cnt_d  = cnt_q - ADDR_WIDTH'(1);
                    gap_d  = GAP_W'(FEED_GAP);
                    if (cnt_q == ADDR_WIDTH'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (bus.abort) begin
                    squash  = 1'b1;
                    state_d = IDLE;
                end else if (out_valid && out_last) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Each issued read carries its valid/last tags down a pipe matching the memory latency.
        vld_d     = '0;
        last_d    = '0;
        vld_d[0]  = issue;
        last_d[0] = issue && (cnt_q == ADDR_WIDTH'(1));
        for (int i = 1; i < RD_LATENCY; i++) begin
            vld_d[i]  = vld_q[i-1];
            last_d[i] = last_q[i-1];
        end
        if (squash) begin
            vld_d  = '0;
            last_d = '0;
        end
    end

    assign bus.busy           = (state_q == ISSUE) || (state_q == DRAIN);
    assign bus.done           = (state_q == FINISH);
    assign bus.mem_rd_en      = issue;
    assign bus.mem_rd_addr    = addr_q;
    assign bus.data_available = out_valid;
    assign bus.feed_complete  = out_valid && out_last;
    assign bus.data           = out_valid ? bus.mem_rd_data : data_q;

endmodule

// File: doc/sample_feeder.md
Name: sample_feeder

Overview:
- Transmitter side of the subchannel sample interface (data_available / feed_complete / data).
- Reads a programmed span of buffered front-end samples from a circular sample memory.
- Presents the samples one at a time with a data_available strobe, and flags the last sample of the span with feed_complete.
- One instance drives the shared sample bus of all subchannels in a channel.

Parameters:
- INPUT_WIDTH, 3, sample word width; matches subchannel data input.
- ADDR_WIDTH, 14, sample memory address width; the buffer depth is 2^ADDR_WIDTH.
- RD_LATENCY, 2, sample memory read latency in cycles; legal range 1..4.
- FEED_GAP, 0, idle cycles inserted between successive read issues; legal range 0..7.

Ports:
- clk  input  1  system clock.
- global_reset  input  1  synchronous active-high reset.
- start  input  1  single-cycle request to begin a feed.
- start_addr  input  ADDR_WIDTH  first sample address; sampled when start is accepted.
- num_samples  input  ADDR_WIDTH  span length in samples; sampled when start is accepted.
- abort  input  1  cancels the feed in progress.
- stall  input  1  while high, no new memory reads are issued.
- busy  output  1  feed in progress.
- done  output  1  single-cycle pulse when a feed finishes normally.
- mem_rd_en  output  1  sample memory read strobe.
- mem_rd_addr  output  ADDR_WIDTH  sample memory read address.
- mem_rd_data  input  INPUT_WIDTH  read data, valid RD_LATENCY cycles after mem_rd_en.
- data_available  output  1  sample strobe to the subchannels.
- data  output  INPUT_WIDTH  sample value; meaningful only while data_available=1.
- feed_complete  output  1  marks the final sample of the span.

Behaviour:
- Reset: busy, done, mem_rd_en, data_available and feed_complete are 0; mem_rd_addr and data are 0; the FSM is IDLE; all in-flight reads are discarded.
- FSM states: IDLE, ISSUE, DRAIN, FINISH.
- IDLE:
  - start=1 with num_samples!=0: latch start_addr and num_samples, go to ISSUE, busy=1 from the next cycle.
  - start with num_samples=0 is ignored; no outputs change.
- ISSUE:
  - Issue one read (mem_rd_en=1, mem_rd_addr=current address) whenever stall=0 and the gap counter is 0.
  - After each issue: address increments modulo 2^ADDR_WIDTH (wraps from all-ones to 0), the issue counter decrements, and the gap counter loads FEED_GAP.
  - The gap counter decrements on every cycle it is nonzero, whether or not stall is high.
  - Go to DRAIN on the cycle the last read issues.
- Read pipeline:
  - An RD_LATENCY-deep valid/last shift register tracks each issued read.
  - data_available=1 and data=mem_rd_data exactly RD_LATENCY cycles after the matching mem_rd_en.
  - feed_complete=1 in the same cycle as the data_available of the final sample, and in no other cycle.
- DRAIN: wait until the pipeline is empty (the final data_available has occurred), then go to FINISH.
- FINISH: done=1 for one cycle, busy=0 in that same cycle, return to IDLE. A start in the FINISH cycle is ignored.
- Latency: start accepted in cycle 0 → first mem_rd_en in cycle 1 → first data_available in cycle 1+RD_LATENCY. With FEED_GAP=0 and no stall, a span of N samples ends with feed_complete in cycle N+RD_LATENCY and done in cycle N+RD_LATENCY+1.
- stall affects only issue. Reads already in flight still deliver on schedule, so stall never drops or duplicates a sample.
- start while busy=1 is ignored.
- abort=1, any state other than IDLE:
  - The next cycle is IDLE with busy=0.
  - All in-flight reads are squashed: no data_available or feed_complete after the abort cycle, and no done pulse.
  - abort has priority over start in the same cycle.
  - abort in IDLE has no effect.
- A global_reset mid-feed behaves like abort, and additionally applies the reset values above.
- data holds its last value when data_available=0.

Test Plan:
- RD_LATENCY=2, FEED_GAP=0; start at cycle 0 with start_addr=10, num_samples=4, memory[a]=a[2:0]:
  - mem_rd_en high in cycles 1-4 with addresses 10-13.
  - data_available high in cycles 3-6 with data 2,3,4,5.
  - feed_complete only in cycle 6; done only in cycle 7; busy high in cycles 1-6.
- Wrap: ADDR_WIDTH=14, start_addr=16382, num_samples=4 → read addresses 16382, 16383, 0, 1; exactly 4 data_available strobes; feed_complete on the 4th.
- Stall: num_samples=6, stall high in cycles 3-5 → no mem_rd_en in cycles 3-5; in-flight samples still appear; 6 samples delivered in address order; feed_complete on the 6th; done one cycle later.
- FEED_GAP=2, num_samples=3 from address 0 → mem_rd_en in cycles 1, 4 and 7; data_available in cycles 3, 6 and 9; feed_complete in cycle 9.
- Abort: num_samples=100, abort in cycle 20 → busy=0 in cycle 21; no data_available, feed_complete or done from cycle 21 on; a new start in cycle 22 is accepted and its feed runs normally.
- Ignored requests:
  - start with num_samples=0 → no memory reads and no outputs change.
  - start while busy → the current span completes unchanged, with exactly its programmed sample count.
